// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store initiator.
// Sizes are in bytes, matching datamem's xfer_size encoding.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mac_state_t;

  localparam logic [3:0] SZ_BYTE = 4'd1;
  localparam logic [3:0] SZ_HALF = 4'd2;
  localparam logic [3:0] SZ_WORD = 4'd4;

  function automatic logic is_legal_size(
    input logic [3:0] s
  );
    return (s == SZ_BYTE) ||
           (s == SZ_HALF) ||
           (s == SZ_WORD);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response and datamem bus of mem_access_ctrl.
// master = pipeline + datamem side, slave = controller.
interface mem_access_ctrl_if;
  import mem_access_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_size;
  logic        req_signed;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] mem_address;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_xfer_size;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_addr,
    output req_size, req_signed, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, mem_address,
    input  mem_write_enable, mem_read_enable,
    input  mem_write_data, mem_xfer_size
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_size, req_signed, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, mem_address,
    output mem_write_enable, mem_read_enable,
    output mem_write_data, mem_xfer_size
  );

endinterface

// File: rtl/load_extend.sv
// Zero/sign extension of a little-endian load result.
// Bytes above the access size are always discarded.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] raw_i,
  input  logic [3:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = raw_i;
    unique case (1'b1)
      size_i == SZ_BYTE:
        data_o = {{24{signed_i & raw_i[7]}},
                  raw_i[7:0]};
      size_i == SZ_HALF:
        data_o = {{16{signed_i & raw_i[15]}},
                  raw_i[15:0]};
      default:
        data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store initiator in front of datamem: checks bounds and
// size, splits misaligned accesses into byte transfers.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_ctrl_if.slave bus
);

  mac_state_t  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] asm_q;
  logic [3:0]  size_q;
  logic        write_q;
  logic        signed_q;
  logic        err_q;
  logic        mis_q;
  logic [2:0]  k_q;

  logic [32:0] end_d;
  logic        req_err_d;
  logic        req_mis_d;
  logic        last_d;
  logic        acc_d;
  logic [4:0]  sh_d;
  logic [31:0] ext_d;

  // 33-bit sum so an address wrap is caught as out of bounds
  assign end_d = {1'b0, bus.req_addr} +
                 {29'b0, bus.req_size};
  assign req_err_d = !is_legal_size(bus.req_size) ||
                     (end_d > 33'(MEM_SIZE));
  assign req_mis_d = (bus.req_addr[3:0] &
                      (bus.req_size - 4'd1)) != 4'd0;

  assign last_d = !mis_q ||
                  ({1'b0, k_q} == size_q - 4'd1);
  assign sh_d   = {k_q[1:0], 3'b000};
  assign acc_d  = state_q == ACCESS;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      size_q   <= SZ_WORD;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            size_q   <= bus.req_size;
            write_q  <= bus.req_write;
            signed_q <= bus.req_signed;
            err_q    <= req_err_d;
            mis_q    <= req_mis_d;
            asm_q    <= '0;
            k_q      <= '0;
            state_q  <= req_err_d ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (!write_q) begin
            if (mis_q)
              asm_q[sh_d +: 8] <= bus.mem_read_data[7:0];
            else
              asm_q <= bus.mem_read_data;
          end
          if (last_d)
            state_q <= RESP;
          else
            k_q <= k_q + 3'd1;
        end
        RESP: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  load_extend u_ext (
    .raw_i    (asm_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_d)
  );

  assign bus.req_ready  = state_q == IDLE;
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = (state_q == RESP) ?
                          ext_d : '0;

  // k_q stays 0 for aligned requests
  assign bus.mem_address = acc_d ?
    addr_q + {29'b0, k_q} : '0;
  assign bus.mem_write_enable = acc_d && write_q;
  assign bus.mem_read_enable  = acc_d && !write_q;
  assign bus.mem_write_data = !acc_d ? '0 :
    mis_q ? {24'b0, wdata_q[sh_d +: 8]} : wdata_q;
  assign bus.mem_xfer_size = !acc_d ? SZ_WORD :
    mis_q ? SZ_BYTE : size_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Random and directed bench for mem_access_ctrl with a
// byte-array datamem and a transaction-level reference model.
module tb_mem_access_ctrl;
  localparam int MS = 1024;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0]  dmem [MS];
  logic [7:0]  rmem [MS];
  logic [31:0] rd_a;
  logic [31:0] wr_a;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.MEM_SIZE(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // datamem: bytes above xfer_size read back as junk
  always_comb begin
    bus.mem_read_data = '0;
    rd_a = '0;
    if (bus.mem_read_enable)
      for (int i = 0; i < 4; i++) begin
        rd_a = bus.mem_address + 32'(i);
        if (i < int'(bus.mem_xfer_size))
          bus.mem_read_data[8*i +: 8] = dmem[rd_a[9:0]];
        else
          bus.mem_read_data[8*i +: 8] = 8'hA5;
      end
  end

  always @(negedge clk) begin
    if (bus.mem_write_enable || bus.mem_read_enable) begin
      check("dm_one_en", {31'b0, bus.mem_write_enable &
            bus.mem_read_enable}, 0);
      check("dm_align", bus.mem_address &
            (32'(bus.mem_xfer_size) - 1), 0);
      check("dm_bound", {31'b0,
            (33'(bus.mem_address) +
             33'(bus.mem_xfer_size)) <= 33'(MS)}, 1);
    end
    if (bus.mem_write_enable)
      for (int i = 0; i < 4; i++)
        if (i < int'(bus.mem_xfer_size)) begin
          wr_a = bus.mem_address + 32'(i);
          dmem[wr_a[9:0]] = bus.mem_write_data[8*i +: 8];
        end
  end

  task automatic do_req(input logic w,
                        input logic [31:0] a,
                        input logic [3:0] s,
                        input logic sg,
                        input logic [31:0] wd);
    logic e, al, done;
    int lat, exp_acc, nacc, cyc;
    logic [31:0] exp_rd, ea, ew;
    longint unsigned endb, acc;
    endb = longint'(a) + longint'(s);
    e = !(s == 1 || s == 2 || s == 4) || endb > MS;
    al = !e && (a % 32'(s) == 0);
    lat = e ? 1 : (al ? 2 : int'(s) + 1);
    exp_acc = e ? 0 : (al ? 1 : int'(s));
    exp_rd = '0;
    if (!e && !w) begin
      acc = 0;
      for (int i = 0; i < int'(s); i++)
        acc += longint'(rmem[int'(a) + i]) << (8 * i);
      if (sg && s < 4 && acc >= (64'd1 << (8*s - 1)))
        acc = acc + 64'h1_0000_0000 - (64'd1 << (8*s));
      exp_rd = acc[31:0];
    end
    if (!e && w)
      for (int i = 0; i < int'(s); i++)
        rmem[int'(a) + i] = 8'(wd >> (8 * i));

    @(negedge clk);
    check("ready", {31'b0, bus.req_ready}, 1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_size   = s;
    bus.req_signed = sg;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_size   = 4'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_wdata  = $urandom;
    nacc = 0;
    done = 1'b0;
    cyc  = 1;
    while (!done && cyc <= 8) begin
      if (cyc == 1)
        check("busy", {31'b0, bus.req_ready}, 0);
      if (bus.mem_write_enable || bus.mem_read_enable) begin
        ea = al ? a : a + 32'(nacc);
        ew = al ? wd : ((wd >> (8 * nacc)) & 32'hFF);
        check("maddr", bus.mem_address, ea);
        check("msize", 32'(bus.mem_xfer_size),
              al ? 32'(s) : 32'd1);
        check("mdir", {31'b0, bus.mem_write_enable},
              {31'b0, w});
        if (w) check("mwdata", bus.mem_write_data, ew);
        nacc++;
      end
      if (bus.resp_valid) begin
        done = 1'b1;
        check("lat", 32'(cyc), 32'(lat));
        check("err", {31'b0, bus.resp_err}, {31'b0, e});
        check("rdata", bus.resp_rdata, exp_rd);
      end else begin
        cyc++;
        @(negedge clk);
      end
    end
    if (!done) check("timeout", 0, 1);
    check("nacc", 32'(nacc), 32'(exp_acc));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 1);
    check({tag, "_rv"}, {31'b0, bus.resp_valid}, 0);
    check({tag, "_re"}, {31'b0, bus.resp_err}, 0);
    check({tag, "_rd"}, bus.resp_rdata, 0);
    check({tag, "_en"}, {30'b0, bus.mem_write_enable,
          bus.mem_read_enable}, 0);
    check({tag, "_ma"}, bus.mem_address, 0);
    check({tag, "_mw"}, bus.mem_write_data, 0);
    check({tag, "_ms"}, 32'(bus.mem_xfer_size), 4);
  endtask

  int unsigned r;
  logic [3:0]  rs;
  logic [31:0] ra;
  int          nbad;

  initial begin
    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_size   = '0;
    bus.req_signed = 1'b0;
    bus.req_wdata  = '0;
    for (int i = 0; i < MS; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end
    repeat (2) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;

    do_req(1, 32'h010, 4, 0, 32'hDEADBEEF);
    do_req(0, 32'h010, 4, 0, 0);
    do_req(1, 32'h003, 2, 0, 32'h0000_1234);
    do_req(0, 32'h003, 2, 1, 0);
    do_req(1, 32'h020, 1, 0, 32'h0000_0080);
    do_req(0, 32'h020, 1, 1, 0);
    do_req(0, 32'h020, 1, 0, 0);
    do_req(0, 32'h020, 4, 1, 0);
    do_req(0, 32'h3FE, 4, 0, 0);
    do_req(0, 32'h000, 3, 0, 0);
    do_req(0, 32'hFFFFFFFF, 2, 0, 0);
    do_req(1, 32'h3FF, 2, 0, 32'hFFFF);
    do_req(0, 32'h3FC, 4, 0, 0);

    // reset in the second byte of a split word store
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 32'h001;
    bus.req_size  = 4'd4;
    bus.req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("mid");
    rmem[1] = 8'hDD;
    rmem[2] = 8'hCC;
    repeat (4) begin
      @(negedge clk);
      check("abort_rv", {31'b0, bus.resp_valid}, 0);
    end
    for (int i = 1; i < 5; i++)
      check("abort_mem", {24'b0, dmem[i]}, {24'b0, rmem[i]});

    // held req_valid with a second request queued
    @(negedge clk);
    check("hold_rdy0", {31'b0, bus.req_ready}, 1);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h040;
    bus.req_size   = 4'd4;
    bus.req_signed = 1'b0;
    bus.req_wdata  = 32'h13579BDF;
    for (int i = 0; i < 4; i++)
      rmem[64 + i] = 8'(32'h13579BDF >> (8 * i));
    @(posedge clk);
    #1;
    bus.req_write = 1'b0;
    bus.req_wdata = 32'h0;
    @(negedge clk);
    check("hold_rdy1", {31'b0, bus.req_ready}, 0);
    check("hold_we1", {31'b0, bus.mem_write_enable}, 1);
    @(negedge clk);
    check("hold_rv2", {31'b0, bus.resp_valid}, 1);
    check("hold_rdy2", {31'b0, bus.req_ready}, 0);
    @(negedge clk);
    check("hold_rdy3", {31'b0, bus.req_ready}, 1);
    check("hold_rv3", {31'b0, bus.resp_valid}, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("hold_re4", {31'b0, bus.mem_read_enable}, 1);
    check("hold_rdy4", {31'b0, bus.req_ready}, 0);
    @(negedge clk);
    check("hold_rv5", {31'b0, bus.resp_valid}, 1);
    check("hold_rd5", bus.resp_rdata, 32'h13579BDF);

    for (int n = 0; n < 300; n++) begin
      r = $urandom % 8;
      case (r)
        0, 1:    rs = 4'd1;
        2, 3:    rs = 4'd2;
        4, 5, 6: rs = 4'd4;
        default: rs = 4'($urandom);
      endcase
      if ($urandom % 16 == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, MS - 1));
      do_req(1'($urandom), ra, rs, 1'($urandom), $urandom);
    end

    nbad = 0;
    for (int i = 0; i < MS; i++)
      if (dmem[i] !== rmem[i]) nbad++;
    check("mem_image", 32'(nbad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator that sits between the pipeline's memory stage and `datamem`, driving `datamem`'s address, enable, size and write-data inputs and consuming its `read_data`. It accepts arbitrary (including misaligned) byte, halfword and word requests. Aligned requests are issued as one `datamem` transfer; misaligned ones are split into sequential byte transfers. Loads are zero- or sign-extended, and out-of-bounds or illegal-size requests are rejected with an error response, so `datamem`'s alignment and bounds assertions never fire.

## Interface
- `MEM_SIZE`, default 1024: bytes in the attached data memory; must be a power of two.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: controller can accept; high only in IDLE.
- `req_write` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address, any alignment.
- `req_size` input 4: bytes; legal values 1, 2, 4.
- `req_signed` input 1: sign-extend load result (sizes 1, 2 only).
- `req_wdata` input 32: store data, little-endian, low `req_size` bytes used.
- `resp_valid` output 1: one-cycle pulse, request finished.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `resp_err` output 1: valid with `resp_valid`; request rejected.
- `mem_address` output 32: to `datamem.address`.
- `mem_write_enable` output 1: to `datamem.write_enable`.
- `mem_read_enable` output 1: to `datamem.read_enable`.
- `mem_write_data` output 32: to `datamem.write_data`.
- `mem_xfer_size` output 4: to `datamem.xfer_size`.
- `mem_read_data` input 32: from `datamem.read_data`, combinational in the same cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request (addr, size, write, signed, wdata).
  - Error if size ∉ {1,2,4} or `addr + size > MEM_SIZE`. Compute the bound check in 33 bits so wrap-around counts as out of bounds.
  - Error goes to RESP with `resp_err`=1, and no memory enable is ever asserted.
  - Otherwise go to ACCESS. Set byte counter k=0 and clear the assembly register.
- Aligned means `(addr & (size-1)) == 0`.
- ACCESS, aligned:
  - One cycle with `mem_address`=addr, `mem_xfer_size`=size, `mem_write_data`=wdata, and the enable matching `req_write`.
  - For loads, capture `mem_read_data` at the cycle's end.
  - Then go to RESP.
- ACCESS, misaligned: `size` cycles, one per byte k = 0..size-1.
  - Each cycle drives `mem_address`=addr+k, `mem_xfer_size`=1, `mem_write_data`={24'b0, wdata[8k+7:8k]}.
  - For loads, `mem_read_data[7:0]` is stored into assembly byte k.
  - After k=size-1, go to RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle.
  - `resp_rdata` is the assembly register, zero-extended, or sign-extended from bit 8·size−1 when `req_signed` and size<4. Bytes at and above `size` are never taken from `mem_read_data`.
  - Then go to IDLE.
- Outside ACCESS: both mem enables are 0, `mem_address`/`mem_write_data` are 0, and `mem_xfer_size`=4.
- No response backpressure; the consumer must take `resp_valid` when it pulses.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, mem enables 0, `mem_address`=0, `mem_write_data`=0, `mem_xfer_size`=4.
- All mem_* outputs are driven from registers/state only. There is no combinational path from `req_*` to `mem_*`.
- Latency, counting edge 0 as the accept edge:
  - Aligned: ACCESS in cycle 1, `resp_valid` in cycle 2.
  - Misaligned size S: ACCESS in cycles 1..S, `resp_valid` in cycle S+1.
  - Error: `resp_valid` in cycle 1.
- Throughput: the next request is accepted in the cycle after RESP (IDLE). Aligned back-to-back: one request per 3 cycles.
- A store byte is committed at the rising edge ending its ACCESS cycle.
- `reset` asserted in any state returns to IDLE at that edge, with all outputs at reset values from the next cycle.
  - Reset mid-split: bytes already written stay written, and no `resp_valid` is produced for the aborted request.
- `req_valid` while not in IDLE is ignored; the requester must hold the request.

## Structure
- Shared package `mem_access_pkg`:
  - state enum `mac_state_t` {IDLE, ACCESS, RESP};
  - size constants `SZ_BYTE`=1, `SZ_HALF`=2, `SZ_WORD`=4;
  - function `is_legal_size`.
- Sub-module `load_extend`: combinational. Inputs are 32-bit raw data, size, and the signed flag; output is the 32-bit extended result. It is used in RESP and is reusable by the pipeline.
- The top level holds the FSM, request latch, byte counter (3 bits) and assembly register. Target is 150–250 lines of RTL.

## Test plan
- **Aligned word round trip.** Store 0xDEADBEEF at 0x010, then load size 4 at 0x010.
  - One ACCESS cycle each, with `mem_xfer_size`=4.
  - Load returns `resp_rdata`=0xDEADBEEF, `resp_err`=0, and `resp_valid` 2 cycles after accept.
- **Misaligned halfword.** Store 0x1234 size 2 at 0x003.
  - Two ACCESS cycles: (0x003, byte 0x34) then (0x004, byte 0x12).
  - Then load size 2 signed at 0x003 → 0x00001234, with `resp_valid` 3 cycles after accept.
- **Sign extension.** Store byte 0x80 at 0x020.
  - Signed byte load → 0xFFFFFF80.
  - Unsigned byte load → 0x00000080.
  - Signed word load at 0x020 ignores `req_signed` for size 4.
- **Bounds and illegal size.**
  - Load size 4 at 0x3FE (MEM_SIZE 1024) → `resp_err`=1 and `resp_rdata`=0 in cycle 1; no mem enable ever high.
  - Size 3 at 0x000 → same.
  - Address 0xFFFFFFFF size 2 → error (wrap).
- **Reset mid-split.**
  - Misaligned word store 0xAABBCCDD at 0x001; assert `reset` during the 2nd ACCESS cycle.
  - Only 0x001=0xDD and 0x002=0xCC are written; no `resp_valid`; `req_ready`=1 the next cycle.
- **Busy hold.** Hold `req_valid` continuously with two different queued requests.
  - Each is accepted only in IDLE.
  - `req_ready`=0 during ACCESS/RESP, and responses come in order.
